// File: rtl/ising_pkg.sv
// ising_pkg: shared readout FSM states and synchronizer depth.
package ising_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/spin_readout_if.sv
// spin_readout_if: host-side measurement request and result handshake.
interface spin_readout_if #(
  parameter int N = 3,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] window;
  logic             busy;
  logic             valid;
  logic             ready;
  logic [N-1:0]     spins;
  logic [N*CNT_W-1:0] agree;
  modport master(output start, window, ready, input busy, valid, spins, agree);
  modport slave(input start, window, ready, output busy, valid, spins, agree);
endinterface

// File: rtl/bit_sync.sv
// bit_sync: single-bit multi-flop synchronizer with async active-high reset.
module bit_sync
  import ising_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] s;
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= '0;
    else s <= {s[SYNC_STAGES-2:0], d};
  assign q = s[SYNC_STAGES-1];
endmodule

// File: rtl/spin_readout.sv
// spin_readout: resolves each oscillator's phase against the reference into a spin
// bit plus an agreement count, measured over a programmable sample window.
module spin_readout
  import ising_pkg::*;
#(
  parameter int N = 3,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] osc_in,
  input  logic         ref_in,
  spin_readout_if.slave bus
);
  state_t             state, state_nx;
  logic [N-1:0]       osc_s, spin_nx, spins_q;
  logic               ref_s, accept, last;
  logic [CNT_W-1:0]   win_q, cnt;
  logic [N*CNT_W-1:0] agree_nx, agree_q;

  bit_sync u_ref (.clk, .rst, .d(ref_in), .q(ref_s));

  assign accept = state == IDLE && bus.start;
  assign last = state == MEASURE && cnt + CNT_W'(1) == win_q;

  for (genvar i = 0; i < N; i++) begin : g_osc
    logic [CNT_W-1:0] acc;
    bit_sync u_osc (.clk, .rst, .d(osc_in[i]), .q(osc_s[i]));
    assign agree_nx[i*CNT_W +: CNT_W] = acc + CNT_W'(osc_s[i] == ref_s);
    // 2*agree >= window at CNT_W+1 bits; a tie counts as in-phase
    assign spin_nx[i] = {agree_nx[i*CNT_W +: CNT_W], 1'b0} >= {1'b0, win_q};
    always_ff @(posedge clk or posedge rst)
      if (rst) acc <= '0;
      else if (accept) acc <= '0;
      else if (state == MEASURE) acc <= agree_nx[i*CNT_W +: CNT_W];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.start ? (bus.window == '0 ? DONE : MEASURE) : IDLE;
      MEASURE: state_nx = last ? DONE : MEASURE;
      DONE:    state_nx = bus.ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = state != IDLE;
    bus.valid = state == DONE;
  end

  // Result registers are separate from the counters so they hold past the handshake
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      win_q <= '0;
      cnt <= '0;
      spins_q <= '0;
      agree_q <= '0;
    end else if (accept) begin
      win_q <= bus.window;
      cnt <= '0;
      if (bus.window == '0) begin
        spins_q <= '1;
        agree_q <= '0;
      end
    end else if (state == MEASURE) begin
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        spins_q <= spin_nx;
        agree_q <= agree_nx;
      end
    end

  assign bus.spins = spins_q;
  assign bus.agree = agree_q;
endmodule
